// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and sizes for the memory arbiter           |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int MEM_AW    = 4;
    localparam int MEM_DW    = 64;
    localparam int MEM_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_if : requester handshake and memory port bundle           |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 4,
    parameter int DW      = 64
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic [DW-1:0]         rdata;
    logic                  mem_we;
    logic [63:0]           mem_addr;
    logic [DW-1:0]         mem_in;
    logic [DW-1:0]         mem_out;

    // Arbiter side
    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_out,
        output gnt, done, rdata, mem_we, mem_addr, mem_in
    );

    // Clients plus memory side
    modport master (
        output req, req_we, req_addr, req_wdata, mem_out,
        input  gnt, done, rdata, mem_we, mem_addr, mem_in
    );
endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, search starts at ptr+1    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [IW-1:0] i_ptr,
    output logic               o_valid,
    output logic [IW-1:0]      o_winner
);
    int unsigned w_idx;

    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        // k = N wraps back to ptr itself, so the last-served requester is tried last
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = IW'(w_idx);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : round-robin sharing of one single-port memory, 3 cycles |
// | per transaction (IDLE -> ACCESS -> DONE). Revision: 1.0               |
// +----------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = MEM_AW,
    parameter int DW      = MEM_DW
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              r_state;
    logic [SW-1:0]       r_sel;
    logic [SW-1:0]       r_ptr;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [DW-1:0]       r_rdata;

    logic                w_valid;
    logic [SW-1:0]       w_winner;
    logic                w_access;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (SW)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_ptr   <= SW'(NUM_REQ - 1);
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= '0;
                    if (w_valid) begin
                        r_sel   <= w_winner;
                        r_gnt   <= NUM_REQ'(1) << w_winner;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!bus.req_we[r_sel]) begin
                        r_rdata <= bus.mem_out;
                    end
                    r_done  <= r_gnt;
                    r_gnt   <= '0;
                    r_ptr   <= r_sel;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_done  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory port is driven only while a grant is active; rst_n gates the write strobe
    assign w_access     = (r_state == ST_ACCESS);
    assign bus.mem_we   = w_access & bus.req_we[r_sel] & rst_n;
    assign bus.mem_addr = w_access ? {{(64-AW){1'b0}}, bus.req_addr[int'(r_sel)*AW +: AW]} : 64'd0;
    assign bus.mem_in   = w_access ? bus.req_wdata[int'(r_sel)*DW +: DW] : '0;

    assign bus.gnt   = r_gnt;
    assign bus.done  = r_done;
    assign bus.rdata = r_rdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : directed stimulus with a queue-based done/rdata      |
// | scoreboard, plus a 16x64 memory model. Revision: 1.0                  |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(2), .AW(4), .DW(64)) bus ();

    mem_arbiter #(.NUM_REQ(2), .AW(4), .DW(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Memory model: reset clears every word and takes priority over writes
    logic [63:0] mem [16];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) mem[k] <= 64'd0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[3:0]] <= bus.mem_in;
        end
    end
    assign bus.mem_out = mem[bus.mem_addr[3:0]];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          idx;
        bit          is_rd;
        logic [63:0] data;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        chk("mem_addr_hi_zero", {4'd0, bus.mem_addr[63:4]}, 64'd0);
        if (bus.gnt != 2'b00) chk("gnt_onehot", 64'($onehot(bus.gnt)), 64'd1);
        if (bus.done != 2'b00) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=%b required none", bus.done);
            end else begin
                e = sbq.pop_front();
                chk("done_who", 64'(bus.done), 64'(2'b01 << e.idx));
                if (e.is_rd) chk("rdata", bus.rdata, e.data);
            end
        end
    end

    // Solo transaction from an idle arbiter: starts just after a posedge
    task automatic run1(input int i, input bit we, input logic [3:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rd);
        exp_t x;
        x.idx = i; x.is_rd = !we; x.data = exp_rd;
        sbq.push_back(x);
        bus.req[i] = 1'b1;
        bus.req_we[i] = we;
        bus.req_addr[i*4 +: 4] = addr;
        bus.req_wdata[i*64 +: 64] = wdata;
        @(negedge clk);
        chk("idle_gnt", 64'(bus.gnt), 64'd0);
        @(negedge clk);
        chk("gnt_latency", 64'(bus.gnt), 64'(2'b01 << i));
        chk("mem_addr", bus.mem_addr, {60'd0, addr});
        chk("mem_we", 64'(bus.mem_we), 64'(we));
        @(negedge clk);
        chk("done_latency", 64'(bus.done), 64'(2'b01 << i));
        @(posedge clk);
        #1 bus.req[i] = 1'b0;
    endtask

    task automatic push_exp(input int i, input bit rd, input logic [63:0] d);
        exp_t x;
        x.idx = i; x.is_rd = rd; x.data = d;
        sbq.push_back(x);
    endtask

    initial begin
        logic [1:0] oh;
        int order [4];
        order = '{0, 1, 0, 1};
        rst_n = 1'b0;
        bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run1(0, 1'b0, 4'd5, 64'd0, 64'd0);

        // Single write then read
        run1(0, 1'b1, 4'd3, 64'hDEAD_BEEF_0000_0001, 64'd0);
        run1(0, 1'b0, 4'd3, 64'd0, 64'hDEAD_BEEF_0000_0001);
        run1(1, 1'b1, 4'd9, 64'h1111_2222_3333_4444, 64'd0);

        // Contention with both requests held over four grants
        for (int g = 0; g < 4; g++)
            push_exp(order[g], 1'b1, (order[g] == 0) ? 64'hDEAD_BEEF_0000_0001
                                                     : 64'h1111_2222_3333_4444);
        bus.req_we = 2'b00;
        bus.req_addr = {4'd9, 4'd3};
        bus.req = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            oh = (c % 3 == 1) ? (2'b01 << order[c / 3]) : 2'b00;
            chk("rr_gnt_seq", 64'(bus.gnt), 64'(oh));
        end
        @(posedge clk);
        #1 bus.req = 2'b00;

        // Write/read race on addr 15
        push_exp(0, 1'b0, 64'd0);
        push_exp(1, 1'b1, 64'h5);
        bus.req_we = 2'b01;
        bus.req_addr = {4'hF, 4'hF};
        bus.req_wdata = {64'd0, 64'h5};
        bus.req = 2'b11;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            oh = (c == 1) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
            chk("race_gnt", 64'(bus.gnt), 64'(oh));
            if (c == 2) bus.req[0] = 1'b0;
        end
        @(posedge clk);
        #1 bus.req = 2'b00;

        // Reset during ACCESS of a write to addr 7
        bus.req_we[0] = 1'b1;
        bus.req_addr[3:0] = 4'd7;
        bus.req_wdata[63:0] = 64'hABCD;
        bus.req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_gnt", 64'(bus.gnt), 64'd1);
        chk("mid_we_pre", 64'(bus.mem_we), 64'd1);
        rst_n = 1'b0;
        #1 chk("mid_we_gated", 64'(bus.mem_we), 64'd0);
        @(negedge clk);
        chk("mid_no_done", 64'(bus.done), 64'd0);
        chk("mid_gnt_clr", 64'(bus.gnt), 64'd0);
        bus.req[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run1(0, 1'b0, 4'd7, 64'd0, 64'd0);

        // Address wrap
        run1(1, 1'b1, 4'hF, 64'hCAFE_F00D_0000_000F, 64'd0);
        run1(0, 1'b1, 4'h0, 64'h0000_0000_0000_1234, 64'd0);
        run1(0, 1'b0, 4'hF, 64'd0, 64'hCAFE_F00D_0000_000F);
        run1(1, 1'b0, 4'h0, 64'd0, 64'h0000_0000_0000_1234);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
